// File: rtl/somador_pkg.sv
// Shared constants for the bit-serial adder: default geometry and FSM encoding.
package somador_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT = 4;
  localparam int unsigned ST_W          = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_ADD  = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/somador_completo_1bit.sv
// Combinational 1-bit full adder built from two half-adder cells.
//   a, b     : operand bits
//   cin      : carry in
//   sum      : a ^ b ^ cin
//   carryOut : carry out (OR of the two half-adder carries)
module somador_completo_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carryOut
);

  logic s1;
  logic c1;
  logic c2;

  somador_meio_1bit u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s1),
    .carry (c1)
  );

  somador_meio_1bit u_ha1 (
    .a     (s1),
    .b     (cin),
    .sum   (sum),
    .carry (c2)
  );

  // Both carries can never be high together, so OR is sufficient.
  assign carryOut = c1 | c2;

endmodule

// File: rtl/somador_meio_1bit.sv
// 1-bit half adder cell.
//   a, b  : input bits
//   sum   : a xor b
//   carry : a and b
module somador_meio_1bit (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/somador_serial.sv
// Bit-serial adder: accepts {a, b, cin} via valid/ready, adds one bit pair per
// cycle LSB first through a full-adder cell, then presents {carry_out, sum}
// via a second valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands and initial carry
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, carry_out      : result, held from end of ADD until next accept
//   busy                : high while bits are being added
module somador_serial
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             fa_sum;
  logic             fa_carry;

  // Single full-adder cell fed by the operand LSBs and the running carry.
  somador_completo_1bit u_fa (
    .a        (a_q[0]),
    .b        (b_q[0]),
    .cin      (carry_q),
    .sum      (fa_sum),
    .carryOut (fa_carry)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d         = a;
          b_d         = b;
          carry_d     = cin;
          cnt_d       = '0;
          sum_d       = '0;
          carry_out_d = 1'b0;
          state_d     = ST_ADD;
        end
      end
      ST_ADD: begin
        // Sum bits enter at the MSB, so after WIDTH shifts bit 0 is the first one computed.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          carry_out_d = fa_carry;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ADD);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_somador_serial.sv
// Directed and randomized bench for somador_serial against an arithmetic model.
module tb_somador_serial;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = -1;

  somador_serial #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: plain integer addition split into low WIDTH bits and carry.
  function automatic int ref_total(input int x, input int y, input int c);
    return x + y + c;
  endfunction

  // One full transaction with out_ready high; optionally checks initiation interval.
  task automatic do_op(input int x, input int y, input int c, input bit hold, input bit chk_ii);
    int tot;
    int guard;
    tot       = ref_total(x, y, c);
    a         = W'(x);
    b         = W'(y);
    cin       = c[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 2 * W + 10) begin
      step();
      guard++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    step();
    if (chk_ii && last_acc >= 0) check("init_interval", cyc - last_acc, W + 2);
    last_acc = cyc;
    if (!hold) in_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("in_ready_in_add", int'(in_ready), 0);
    repeat (W - 1) step();
    check("out_valid_early", int'(out_valid), 0);
    step();
    check("out_valid_rise", int'(out_valid), 1);
    check("sum", int'(sum), tot % (1 << W));
    check("carry_out", int'(carry_out), tot / (1 << W));
    step();
    check("out_valid_fall", int'(out_valid), 0);
    check("in_ready_back", int'(in_ready), 1);
  endtask

  initial begin
    int tot;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #12;
    check("rst_sum", int'(sum), 0);
    check("rst_carry_out", int'(carry_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed operands from the plan, including carry boundaries.
    do_op(3, 5, 0, 1'b0, 1'b0);
    do_op(15, 1, 0, 1'b0, 1'b0);
    do_op(15, 15, 1, 1'b0, 1'b0);
    do_op(0, 0, 0, 1'b0, 1'b0);

    // Backpressure: result must hold and new operands must be ignored.
    tot       = ref_total(9, 4, 0);
    a         = W'(9);
    b         = W'(4);
    cin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    check("bp_busy", int'(busy), 1);
    in_valid = 1'b0;
    repeat (W) step();
    check("bp_out_valid", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      step();
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_sum", int'(sum), tot % (1 << W));
      check("bp_hold_carry", int'(carry_out), tot / (1 << W));
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_sum_retained", int'(sum), tot % (1 << W));

    // Asynchronous reset two cycles into ADD aborts the operation.
    a        = W'(7);
    b        = W'(7);
    cin      = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_rst_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_sum", int'(sum), 0);
    check("midrst_carry", int'(carry_out), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_op(1, 1, 0, 1'b0, 1'b0);

    // Randomized operands.
    for (int k = 0; k < 40; k++) begin
      do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Exhaustive back-to-back sweep with in_valid held high.
    last_acc = -1;
    for (int x = 0; x < (1 << W); x++) begin
      for (int y = 0; y < (1 << W); y++) begin
        for (int c = 0; c < 2; c++) begin
          do_op(x, y, c, 1'b1, 1'b1);
        end
      end
    end
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/somador_serial.md
Name: somador_serial

Overview:
- Bit-serial adder stage that drives the 1-bit adder cell.
- Accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake.
- Feeds one bit pair per clock, LSB first, into a full-adder cell and registers each sum bit and carry back.
- Presents the WIDTH-bit sum and final carry to a downstream consumer through a second valid/ready handshake.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 2..16.
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; release is synchronised externally
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  initial carry-in
- out_valid  output  1  sum and carry_out are valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result bits
- carry_out  output  1  final carry out of the MSB
- busy  output  1  high in the ADD state

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - sum=0, carry_out=0, out_valid=0, busy=0, and the internal registers, bit counter and carry register are cleared.
  - in_ready=1 once in IDLE; in_ready is combinational from the state.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a clock edge, latch a and b into shift registers, latch cin into the carry register, clear the counter and sum, and go to ADD.
- ADD (in_ready=0, busy=1):
  - Each cycle, the full-adder cell takes the LSB of each shift register and the carry register.
  - Its sum bit shifts into the MSB of the sum register (right-shift), and its carry replaces the carry register.
  - The operand registers shift right by 1 and the counter increments.
  - After the cycle with counter==WIDTH-1, go to DONE; carry_out takes the final carry.
  - ADD lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1; sum and carry_out are held stable.
  - On out_ready, go to IDLE next cycle, with out_valid=0 and sum/carry_out retained until the next acceptance.
  - in_ready=0 in DONE. A new operand cannot be accepted in the same cycle the result is taken.
- Latency: operand accept at edge N gives out_valid=1 after edge N+WIDTH. Minimum initiation interval is WIDTH+2 cycles.
- Arithmetic: {carry_out,sum} = a + b + cin, modulo 2**(WIDTH+1). No overflow flag; carry_out is the unsigned carry.
- Handshake:
  - in_valid and operands may change freely while in_ready=0; they are ignored.
  - out_ready while out_valid=0 is ignored.
- Backpressure: out_ready may stay low indefinitely. The result is held and no new operands are accepted.
- Reset mid-operation: the operation aborts immediately and no partial result is presented. After reset, the block is in IDLE as above.

Decomposition:
- Shared package somador_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2;
  - default WIDTH=4.
- One sub-module, somador_completo_1bit, is a combinational full adder.
  - Ports: a, b, cin, sum, carryOut.
  - Built from two instances of the existing 1-bit half-adder cell plus an OR of their carries.
  - It is instantiated once inside somador_serial.

Test Plan:
- a=4'd3, b=4'd5, cin=0, out_ready=1, accepted at edge 0 -> out_valid=1 after edge 4 with sum=4'd8, carry_out=0; in_ready=1 again two edges later.
- a=4'hF, b=4'h1, cin=0 -> sum=4'h0, carry_out=1. Then a=4'hF, b=4'hF, cin=1 -> sum=4'hF, carry_out=1.
- Backpressure: a=4'd9, b=4'd4, out_ready held 0 for 5 cycles after out_valid rises -> sum=4'd13, carry_out=0 stable throughout; in_ready=0 and in_valid with new operands ignored; out_ready=1 -> out_valid=0 next cycle.
- Reset mid-operation: accept a=4'd7, b=4'd7, assert rst_n=0 asynchronously two cycles into ADD -> sum=0, carry_out=0, out_valid=0, busy=0 immediately. After release, in_ready=1 and a=4'd1, b=4'd1 gives sum=4'd2.
- Exhaustive sweep: all 512 (a, b, cin) combinations back-to-back with in_valid and out_ready held high -> each result equals a+b+cin and exactly WIDTH+2 cycles elapse between accepts.
